// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser
//   Deframes the received UART byte stream into packets of the form
//   SYNC, CMD, LEN, payload[LEN], CHK. Payload bytes leave through a
//   single-entry registered output. A checksum verdict is reported at the
//   end of every packet.
//
//   Optional build macro: UART_PKT_TIMEOUT_EN
//     Defined   - an inter-byte idle counter aborts a stalled packet after
//                 TIMEOUT_CYCLES clocks (err_code 3).
//     Undefined - no counter; the parser waits indefinitely in any state.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   in_data/in_valid    byte stream from uart_front
//   in_ready            back to uart_front (combinational)
//   out_data/out_valid  registered payload byte stream
//   out_ready           downstream accept
//   out_last            marks the final payload byte of a packet
//   pkt_cmd/pkt_len     CMD/LEN of the current or last packet
//   pkt_start           one-cycle pulse when CMD is accepted
//   pkt_done/pkt_ok     end-of-packet pulse and checksum verdict
//   err_code            0 none, 1 checksum, 2 length, 3 timeout
//
// State table
//   S_IDLE    | hunting for SYNC_BYTE, other bytes discarded
//   S_CMD     | next byte is CMD
//   S_LEN     | next byte is LEN
//   S_PAYLOAD | forwarding LEN payload bytes
//   S_CHK     | next byte is the checksum byte
module uart_pkt_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] pkt_cmd,
  output logic [7:0] pkt_len,
  output logic       pkt_start,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic [1:0] err_code
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;

  localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

  logic [2:0] r_state;
  logic [7:0] r_acc;
  logic [7:0] r_cnt;

  logic       w_accept;
  logic       w_load;
  logic [7:0] w_sum;
  logic       w_timeout;

  // Payload may only be taken when the output register is free or draining.
  assign in_ready = (r_state == S_PAYLOAD) ? (!out_valid || out_ready) : 1'b1;
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && (r_state == S_PAYLOAD);
  assign w_sum    = r_acc + in_data;

`ifdef UART_PKT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_idle_cnt;
  logic        w_stalled;

  // A blocked output is downstream's fault, not the sender's: freeze.
  assign w_stalled = out_valid && !out_ready;
  assign w_timeout = (r_state != S_IDLE) && !w_accept && !w_stalled &&
                     (r_idle_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= 16'd0;
    end else if ((r_state == S_IDLE) || w_accept || w_timeout) begin
      r_idle_cnt <= 16'd0;
    end else if (!w_stalled) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Output skid register: load wins over drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (w_load) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
      out_last  <= (r_cnt == 8'd1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 8'd0;
      r_cnt     <= 8'd0;
      pkt_cmd   <= 8'd0;
      pkt_len   <= 8'd0;
      pkt_start <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      pkt_start <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_ok    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (in_data == SYNC_BYTE)) r_state <= S_CMD;
        end
        S_CMD: begin
          if (w_accept) begin
            pkt_cmd   <= in_data;
            r_acc     <= in_data;
            pkt_start <= 1'b1;
            err_code  <= 2'd0;
            r_state   <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            pkt_len <= in_data;
            r_acc   <= w_sum;
            if (in_data > MAX_LEN_B) begin
              pkt_done <= 1'b1;
              err_code <= 2'd2;
              r_acc    <= 8'd0;
              r_state  <= S_IDLE;
            end else if (in_data == 8'd0) begin
              r_state <= S_CHK;
            end else begin
              r_cnt   <= in_data;
              r_state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) r_state <= S_CHK;
          end
        end
        S_CHK: begin
          // A CHK equal to SYNC_BYTE is only a checksum; no new packet starts.
          if (w_accept) begin
            pkt_done <= 1'b1;
            pkt_ok   <= (w_sum == 8'd0);
            err_code <= (w_sum == 8'd0) ? 2'd0 : 2'd1;
            r_acc    <= 8'd0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        pkt_done <= 1'b1;
        pkt_ok   <= 1'b0;
        err_code <= 2'd3;
        r_acc    <= 8'd0;
        r_cnt    <= 8'd0;
        r_state  <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Testbench for uart_pkt_parser: packets are built from random fields, the
// expected payload stream and verdict are derived from the packet contents,
// and monitors compare whatever the DUT presents against those queues.
module tb_uart_pkt_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] pkt_cmd;
  logic [7:0] pkt_len;
  logic       pkt_start;
  logic       pkt_done;
  logic       pkt_ok;
  logic [1:0] err_code;

  uart_pkt_parser dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last),
    .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } pay_t;

  typedef struct {
    logic       ok;
    logic [1:0] err;
    logic [7:0] cmd;
    logic [7:0] len;
  } res_t;

  pay_t       exp_pay[$];
  res_t       exp_res[$];
  logic [7:0] exp_start[$];
  logic [7:0] tx_q[$];
  logic [7:0] pl[$];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         rdy_mode = 0;
  int         max_gap  = 0;
  logic       mon_en   = 1'b0;
  logic [7:0] last_len = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // out_ready pattern generator
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 4 == 0);
        default: out_ready = ($urandom % 3 != 0);
      endcase
    end
  end

  // Monitor: payload stream, hold stability, handshake rule, packet events
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_last;
    pay_t       p;
    res_t       r;
    logic [7:0] c;
    prev_hold = 1'b0;
    prev_data = 8'd0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(prev_data));
          check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (!in_ready) check("in_ready_low_only_when_blocked", 32'(out_valid && !out_ready), 32'd1);
        if (out_valid && out_ready) begin
          if (exp_pay.size() == 0) fail_now("payload_unexpected");
          else begin
            p = exp_pay.pop_front();
            check("payload_data", 32'(out_data), 32'(p.data));
            check("payload_last", 32'(out_last), 32'(p.last));
          end
        end
        if (pkt_start && pkt_done) fail_now("start_done_overlap");
        if (pkt_start) begin
          if (exp_start.size() == 0) fail_now("pkt_start_unexpected");
          else begin
            c = exp_start.pop_front();
            check("start_cmd", 32'(pkt_cmd), 32'(c));
            check("start_err_clear", 32'(err_code), 32'd0);
          end
        end
        if (pkt_done) begin
          if (exp_res.size() == 0) fail_now("pkt_done_unexpected");
          else begin
            r = exp_res.pop_front();
            check("done_ok", 32'(pkt_ok), 32'(r.ok));
            check("done_err", 32'(err_code), 32'(r.err));
            check("done_cmd", 32'(pkt_cmd), 32'(r.cmd));
            check("done_len", 32'(pkt_len), 32'(r.len));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int   waited;
    logic acc;
    waited = 0;
    acc    = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && waited < 400) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_byte: got no acceptance of %0h expected in_ready within 400 cycles", b);
    end
  endtask

  task automatic flush_tx();
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clk);
        #1;
      end
      send_byte(b);
    end
  endtask

  // Reference: a packet's expected outputs follow directly from its fields.
  task automatic issue_pkt(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] chk);
    logic [7:0] sum;
    res_t       r;
    pay_t       p;
    tx_q.push_back(8'hA5);
    tx_q.push_back(cmd);
    tx_q.push_back(len);
    exp_start.push_back(cmd);
    last_len = len;
    r.cmd = cmd;
    r.len = len;
    if (len > 8'd64) begin
      r.ok  = 1'b0;
      r.err = 2'd2;
    end else begin
      sum = cmd + len;
      for (int i = 0; i < int'(len); i++) begin
        tx_q.push_back(pl[i]);
        p.data = pl[i];
        p.last = (i == int'(len) - 1);
        exp_pay.push_back(p);
        sum = sum + pl[i];
      end
      tx_q.push_back(chk);
      sum   = sum + chk;
      r.ok  = (sum == 8'd0);
      r.err = (sum == 8'd0) ? 2'd0 : 2'd1;
    end
    exp_res.push_back(r);
    flush_tx();
  endtask

  task automatic garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      tx_q.push_back(g);
    end
    flush_tx();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_pay.size() + exp_res.size() + exp_start.size()) != 0 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_payload_empty", 32'(exp_pay.size()), 32'd0);
    check("drain_result_empty", 32'(exp_res.size()), 32'd0);
    check("drain_start_empty", 32'(exp_start.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] chk;
    rst      = 1'b1;
    in_data  = 8'd0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_pkt_cmd", 32'(pkt_cmd), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    check("rst_flags", 32'({pkt_start, pkt_done, pkt_ok}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Good packet, then bad checksum
    pl = '{8'h10, 8'h20};
    issue_pkt(8'h01, 8'h02, 8'hCD);
    issue_pkt(8'h01, 8'h02, 8'hCE);
    // Length error, then zero-length packet
    pl = '{};
    issue_pkt(8'h07, 8'h41, 8'h00);
    issue_pkt(8'h03, 8'h00, 8'hFD);
    drain();

    // Garbage and 1-on/3-off backpressure
    rdy_mode = 1;
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'h5A);
    flush_tx();
    pl = '{8'h11, 8'h22, 8'h33};
    issue_pkt(8'h01, 8'h03, 8'hC8);
    drain();

    // Reset mid-payload
    rdy_mode = 0;
    exp_start.push_back(8'h01);
    exp_pay.push_back('{data: 8'h10, last: 1'b0});
    tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10};
    flush_tx();
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_payload_delivered", 32'(exp_pay.size()), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_pkt_cmd", 32'(pkt_cmd), 32'd0);
    check("midrst_pkt_len", 32'(pkt_len), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pay.delete();
    exp_res.delete();
    exp_start.delete();
    last_len = 8'd0;
    // Parser must be hunting for SYNC: these must produce nothing.
    tx_q = '{8'h20, 8'h01, 8'h02};
    flush_tx();
    pl = '{8'h10, 8'h20};
    issue_pkt(8'h01, 8'h02, 8'hCD);
    drain();

`ifdef UART_PKT_TIMEOUT_EN
    begin
      res_t r;
      exp_start.push_back(8'h01);
      r.ok  = 1'b0;
      r.err = 2'd3;
      r.cmd = 8'h01;
      r.len = last_len;
      exp_res.push_back(r);
      tx_q = '{8'hA5, 8'h01};
      flush_tx();
      repeat (700) @(posedge clk);
      #1;
      check("timeout_reported", 32'(exp_res.size()), 32'd0);
      pl = '{8'h10, 8'h20};
      issue_pkt(8'h01, 8'h02, 8'hCD);
      drain();
    end
`endif

    // Randomized packets
    for (int n = 0; n < 40; n++) begin
      rdy_mode = n % 3;
      max_gap  = n % 4;
      garbage($urandom_range(3, 0));
      cmd = 8'($urandom);
      if ($urandom % 10 == 0) len = 8'($urandom_range(255, 65));
      else len = 8'($urandom_range(64, 0));
      pl.delete();
      sum = cmd + len;
      if (len <= 8'd64) begin
        for (int i = 0; i < int'(len); i++) begin
          pl.push_back(8'($urandom));
          sum = sum + pl[i];
        end
      end
      chk = 8'd0 - sum;
      if ($urandom % 3 == 0) chk = chk + 8'($urandom_range(255, 1));
      issue_pkt(cmd, len, chk);
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
Sits directly downstream of uart_front. It consumes the received byte stream through the valid/ready handshake and drives uart_ready. The byte stream is deframed into packets of the form SYNC, CMD, LEN, payload[LEN], CHK. Payload bytes are forwarded to the framebuffer/SD command logic as a registered stream, and a checksum verdict is reported at the end of each packet.

Parameters:
SYNC_BYTE, 8'hA5, start-of-packet marker.
MAX_LEN, 64, largest legal LEN value (1..255).
TIMEOUT_CYCLES, 640, inter-byte timeout in clk cycles (only used with the optional feature).

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
in_data  in  8  byte from uart_front data_rx.
in_valid  in  1  from uart_front uart_valid.
in_ready  out  1  to uart_front uart_ready. Combinational from state and output register.
out_data  out  8  payload byte (registered).
out_valid  out  1  payload byte valid.
out_ready  in  1  downstream accepts the payload byte.
out_last  out  1  marks the final payload byte of a packet.
pkt_cmd  out  8  CMD of the current/last packet. Held until the next CMD byte is accepted.
pkt_len  out  8  LEN of the current/last packet. Held likewise.
pkt_start  out  1  one-cycle pulse when CMD is accepted.
pkt_done  out  1  one-cycle pulse when a packet ends, good or bad.
pkt_ok  out  1  valid with pkt_done: 1 = checksum good.
err_code  out  2  0 none, 1 checksum, 2 length, 3 timeout. Held until the next pkt_start.

Behaviour:
- Byte transfer: a byte is accepted on a rising clk when in_valid && in_ready.
- Reset (asynchronous, any time, including mid-packet):
  - state = IDLE;
  - out_valid, out_last, pkt_start, pkt_done and pkt_ok = 0;
  - out_data, pkt_cmd, pkt_len and err_code = 0;
  - the checksum accumulator and the payload counter are cleared.
- in_ready = 1 in IDLE, CMD, LEN and CHK. In PAYLOAD, in_ready = !out_valid || out_ready (single-entry output skid register).
- Checksum: 8-bit accumulator, wrapping mod 256, over CMD, LEN, every payload byte and CHK. The packet is good when the final sum == 8'h00.
- IDLE: accepted byte == SYNC_BYTE -> CMD. Any other byte is discarded, with no outputs.
- CMD: accept the byte -> pkt_cmd <= byte, accumulator <= byte, pkt_start pulse, err_code <= 0 -> LEN.
- LEN: accept the byte -> pkt_len <= byte, and the byte is added to the accumulator. Then:
  - byte > MAX_LEN -> pkt_done = 1, pkt_ok = 0, err_code = 2 -> IDLE.
  - byte == 0 -> CHK.
  - otherwise -> PAYLOAD, remaining counter <= byte.
- PAYLOAD: each accepted byte is loaded into out_data with out_valid = 1 on the next cycle (latency 1). The byte is added to the accumulator and the counter decrements.
  - The last byte (counter == 1) sets out_last = 1 and moves to CHK.
  - out_valid/out_data/out_last hold stable until out_ready is seen; they clear on that cycle unless a new byte loads simultaneously (accept-and-load in the same cycle is required).
- CHK: accept the byte -> pkt_done pulse one cycle later, with pkt_ok = (sum == 0) and err_code = ok ? 0 : 1 -> IDLE.
  - A CHK byte equal to SYNC_BYTE is treated as checksum only. It does not start a new packet.
- An out_valid still pending when the FSM leaves PAYLOAD remains pending until drained. in_ready in the following states does not depend on it.
- A SYNC_BYTE value inside CMD/LEN/PAYLOAD is ordinary data (no resync).
- pkt_start and pkt_done are never high in the same cycle.

Optional Feature:
UART_PKT_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter runs while state != IDLE. It resets on every accepted byte and freezes while out_valid && !out_ready.
  - When the counter reaches TIMEOUT_CYCLES-1: pkt_done = 1, pkt_ok = 0, err_code = 3, state -> IDLE, accumulator cleared.
  - A pending out_valid byte is still delivered, and out_last is not forced.
- Undefined: no counter is present, and the parser waits indefinitely in any state.

Test Plan:
- Good packet: A5 01 02 10 20 CD, out_ready = 1 -> out_data 10 then 20 (out_last on 20); pkt_cmd = 01, pkt_len = 02; pkt_done with pkt_ok = 1, err_code = 0.
- Bad checksum: A5 01 02 10 20 CE -> both payload bytes are still delivered; pkt_done with pkt_ok = 0, err_code = 1.
- Length error: A5 07 41 (65 > MAX_LEN) -> pkt_done, pkt_ok = 0, err_code = 2, back to IDLE. Next: A5 03 00 FD -> pkt_ok = 1, with no out_valid.
- Backpressure and garbage: 3C 5A before A5 01 03 11 22 33 C8, with out_ready toggling 1 cycle on / 3 off -> garbage is ignored; in_ready drops while out_valid && !out_ready; 11 22 33 are delivered in order with no loss or duplication.
- Reset mid-payload: assert rst after byte 10 of the good packet -> all outputs 0 and state IDLE immediately. A subsequent full good packet passes.
- With UART_PKT_TIMEOUT_EN: A5 01, then silence for 640 cycles -> pkt_done, err_code = 3. Next A5 packet parses correctly.
